// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer sequencer: FSM state encoding,
// register offsets and the default burst size.
package dma_pkg;

    localparam int MAX_BURST_DEF = 16;

    // Register select, taken from reg_addr[3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Byte-lane merge of a write into the current register value.
    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dma_regfile.sv
// Software-visible SRC/DST/LEN registers and CTRL strobes for the DMA sequencer.
// SRC/DST/LEN/START are locked out while a transfer runs; IRQ_CLR never is.
module dma_regfile
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       reg_wen,
    input  logic [31:0]      reg_addr,
    input  logic [31:0]      reg_wdata,
    input  logic             busy,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             start,
    output logic             irq_clr
);

    logic       wr_en;
    logic [1:0] sel;
    logic       unused_addr_bits;

    assign wr_en = |reg_wen;
    assign sel   = reg_addr[3:2];
    assign unused_addr_bits = ^{reg_addr[31:4], reg_addr[1:0]};

    // Both CTRL bits live in byte lane 0, so lane 0 must be enabled to act.
    assign start   = wr_en && (sel == REG_CTRL) && reg_wen[0] && reg_wdata[0] && !busy;
    assign irq_clr = wr_en && (sel == REG_CTRL) && reg_wen[0] && reg_wdata[1];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src <= '0;
            dst <= '0;
            len <= '0;
        end else if (wr_en && !busy) begin
            case (sel)
                REG_SRC: src <= lane_merge(src, reg_wdata, reg_wen) & 32'hFFFF_FFFC;
                REG_DST: dst <= lane_merge(dst, reg_wdata, reg_wen) & 32'hFFFF_FFFC;
                REG_LEN: len <= LEN_W'(lane_merge(32'(len), reg_wdata, reg_wen));
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dma_xfer_sequencer.sv
// Memory-to-memory DMA sequencer: splits a LEN-word copy into read/write AXI
// bursts of at most MAX_BURST words, one burst fully completed before the next.
module dma_xfer_sequencer
    import dma_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  reg_wen,
    input  logic [31:0] reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        wfi_signal,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [3:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_last,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_len,
    input  logic        wr_ack,
    input  logic        wr_done,
    output logic        busy,
    output logic        irq
);

    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             start;
    logic             irq_clr;

    state_t           state;
    logic [31:0]      cur_src;
    logic [31:0]      cur_dst;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] burst;
    logic [3:0]       burst_len;
    logic [31:0]      burst_bytes;
    logic             done_flag;

    dma_regfile #(.LEN_W(LEN_W)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .reg_wen   (reg_wen),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .start     (start),
        .irq_clr   (irq_clr)
    );

    assign burst       = (remaining > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : remaining;
    assign burst_len   = 4'(burst - LEN_W'(1));
    assign burst_bytes = 32'(burst) << 2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_RD_ADDR;
                            cur_src   <= src;
                            cur_dst   <= dst;
                            remaining <= len;
                        end
                    end
                end
                ST_RD_ADDR: if (rd_ack)  state <= ST_RD_DATA;
                ST_RD_DATA: if (rd_last) state <= ST_WR_ADDR;
                ST_WR_ADDR: if (wr_ack)  state <= ST_WR_RESP;
                ST_WR_RESP: begin
                    if (wr_done) begin
                        cur_src   <= cur_src + burst_bytes;
                        cur_dst   <= cur_dst + burst_bytes;
                        remaining <= remaining - burst;
                        state     <= (remaining != burst) ? ST_RD_ADDR : ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A clear in the same cycle as completion wins, so software never loses a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_flag <= 1'b0;
        end else if (irq_clr) begin
            done_flag <= 1'b0;
        end else if (state == ST_DONE) begin
            done_flag <= 1'b1;
        end
    end

    // Burst outputs are zero outside their request state, including in reset.
    assign rd_req  = (state == ST_RD_ADDR);
    assign wr_req  = (state == ST_WR_ADDR);
    assign rd_addr = rd_req ? cur_src   : '0;
    assign rd_len  = rd_req ? burst_len : '0;
    assign wr_addr = wr_req ? cur_dst   : '0;
    assign wr_len  = wr_req ? burst_len : '0;
    assign busy    = (state != ST_IDLE);
    assign irq     = done_flag && wfi_signal;

endmodule
